bound_flasher_gen: RTL
======================

Name: bound_flasher_gen

Overview:
- Parametrised successor to the team's 16-LED bound flasher.
- Drives a thermometer-coded LED bar through a fixed six-phase up/down sequence after a flick request.
- Kickback points at two configurable bounds; configurable bar width and step rate.
- Optional auto-loop mode; status outputs for the surrounding panel controller.

Parameters:
- N_LED, 16, number of LEDs in the bar (4..64).
- B1, 5, lower bound/kickback LED index; require 1 <= B1 < B2.
- B2, 10, upper bound/kickback LED index; require B2 <= N_LED-2. Illegal combinations fail at elaboration.
- STEP_DIV, 1, clock cycles per LED step (1..1024).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flick  in  1  start/kickback request, level sampled on clk.
- loop_en  in  1  when 1, sequence restarts automatically at the end of the last phase.
- led  out  N_LED  LED bar; led = (1<<cnt)-1.
- busy  out  1  1 in every state except IDLE.
- phase  out  3  current state encoding from the package.

Behaviour:
- Internal state:
  - cnt: 0..N_LED, number of lit LEDs, width $clog2(N_LED+1).
  - State register.
  - Prescaler pre: 0..STEP_DIV-1.
  - Sticky flag fl_l.
- Reset (rst=1 at edge): state=IDLE, cnt=0, led=0, busy=0, phase=IDLE, pre=0, fl_l=0. Reset dominates all other events, mid-sequence included.
- Prescaler and flick latch:
  - tick = (pre == STEP_DIV-1).
  - pre increments in non-IDLE states, wraps to 0 on tick, and is held at 0 in IDLE.
  - fl_l is set by flick and cleared on tick.
  - The effective request on a tick is fl = flick | fl_l.
  - With STEP_DIV=1, fl = flick every cycle.
- IDLE: flick=1 -> UP_A next cycle (cnt unchanged, pre=0).
- State actions. All cnt changes and transitions occur only on tick, except IDLE exit.
  - UP_A: cnt++; when cnt == B1+1 -> DN_A.
  - DN_A: cnt--; when cnt == 0 -> UP_B.
  - UP_B: cnt++. When cnt == B2+1 and fl=0 -> DN_B.
    - Kickback: if cnt is B1+1 or B2+1 and fl=1 -> DN_A, cnt-- that tick.
  - DN_B: cnt--; when cnt == B1 (LEDs 0..B1-1 lit) -> UP_C.
  - UP_C: cnt++. When cnt == N_LED and fl=0 -> DN_C.
    - Kickback: if cnt is B1+1 or B2+1 and fl=1 -> DN_B, cnt-- that tick.
  - DN_C: cnt--; when cnt == 0, go to UP_A if loop_en=1 or fl=1, otherwise IDLE.
- Transition semantics: "when cnt == X" means the transition is evaluated on the tick where the registered cnt equals X. The state change takes effect next cycle, and the tick that reaches X performs no further cnt change.
- Flick handling:
  - Flick outside kickback points is ignored but still consumes fl_l at the next tick.
  - Flick during UP_A, DN_A, DN_B and DN_C has no effect, except at the DN_C end.
- Repeated kickbacks are unlimited. Each one re-runs the down phase, then the same up phase.
- No overflow: cnt is never driven above N_LED or below 0 by construction.
- led is registered from cnt and state, not combinational from flick.
- Normal flow, STEP_DIV=1, defaults: 6+6+11+6+11+16 = 56 step cycles after leaving IDLE.

Decomposition:
- bound_flasher_pkg holds:
  - State enum (3-bit): IDLE=0, UP_A=1, DN_A=2, UP_B=3, DN_B=4, UP_C=5, DN_C=6.
  - Function therm(cnt) returning the thermometer vector.
- Sub-module step_prescaler(clk, rst, en, tick), parametrised by STEP_DIV; en = busy.

Test Plan:
- Normal flow: defaults, STEP_DIV=1, flick pulse 1 cycle, loop_en=0 -> led peaks 0x003F, 0x0000, 0x07FF, 0x001F, 0xFFFF, then 0x0000. IDLE after 56 steps; busy high throughout.
- Kickback in UP_B: flick while led=0x003F in UP_B -> next led=0x001F, phase=DN_A. Descends to 0 and re-enters UP_B. Same check at led=0x07FF.
- Kickback in UP_C: flick at led=0x07FF in UP_C -> phase=DN_B, led descends to 0x001F, UP_C repeats to 0xFFFF.
- Non-kickback flick: flick at led=0x00FF in UP_B -> no change, sequence identical to normal flow.
- Prescaler and latch: STEP_DIV=4, 1-cycle flick pulse between ticks at led=0x003F in UP_B -> kickback applied on the next tick. cnt changes only every 4 cycles.
- Reset and loop: rst=1 for 1 cycle mid UP_C -> led=0, phase=IDLE next cycle. With loop_en=1, the end of DN_C goes directly to UP_A (led=0x0001 next step). N_LED=32, B1=8, B2=20: peak led=0xFFFFFFFF.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared state encoding and bar helper
// for the parametrised bound flasher
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP_A = 3'd1,
    DN_A = 3'd2,
    UP_B = 3'd3,
    DN_B = 3'd4,
    UP_C = 3'd5,
    DN_C = 3'd6
  } state_t;

  localparam int MAX_LED = 64;
  localparam int CNT_W_MAX = 7;

  // lowest n bits set, rest clear
  function automatic logic [MAX_LED-1:0] therm(
    input logic [CNT_W_MAX-1:0] n
  );
    logic [MAX_LED-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_LED; i++) begin
      v[i] = (i < int'(n));
    end
    return v;
  endfunction

endpackage

// File: rtl/bound_flasher_gen_if.sv
// bound_flasher_gen_if: panel-side bundle of the flasher
// controller drives requests, flasher drives the bar/status
interface bound_flasher_gen_if #(
  parameter int N_LED = 16
);
  import bound_flasher_pkg::*;

  logic             flick;
  logic             loop_en;
  logic [N_LED-1:0] led;
  logic             busy;
  state_t           phase;

  modport master (
    output flick,
    output loop_en,
    input  led,
    input  busy,
    input  phase
  );

  modport slave (
    input  flick,
    input  loop_en,
    output led,
    output busy,
    output phase
  );

endinterface

// File: rtl/bound_flasher_gen_step_prescaler.sv
// step_prescaler: one tick every STEP_DIV enabled cycles
// counter parks at zero while disabled
module step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(STEP_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = (pre == LAST);

  // count while running, wrap on tick, hold 0 when idle
  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen: six-phase thermometer bar sequencer
// with kickback at two bounds and optional auto-loop
module bound_flasher_gen #(
  parameter int N_LED    = 16,
  parameter int B1       = 5,
  parameter int B2       = 10,
  parameter int STEP_DIV = 1
) (
  input logic clk,
  input logic rst,
  bound_flasher_gen_if.slave bus
);
  import bound_flasher_pkg::*;

  if (N_LED < 4 || N_LED > 64) begin : g_bad_n
    $error("N_LED must be within 4..64");
  end
  if (B1 < 1 || B1 >= B2) begin : g_bad_b1
    $error("B1 must satisfy 1 <= B1 < B2");
  end
  if (B2 > N_LED - 2) begin : g_bad_b2
    $error("B2 must not exceed N_LED-2");
  end
  if (STEP_DIV < 1 || STEP_DIV > 1024) begin : g_bad_d
    $error("STEP_DIV must be within 1..1024");
  end

  localparam int CW = $clog2(N_LED + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t K1 = cnt_t'(B1 + 1);
  localparam cnt_t K2 = cnt_t'(B2 + 1);
  localparam cnt_t KB = cnt_t'(B1);
  localparam cnt_t KN = cnt_t'(N_LED);
  localparam cnt_t ONE = cnt_t'(1);

  state_t           state;
  state_t           state_n;
  cnt_t             cnt;
  cnt_t             cnt_n;
  logic [N_LED-1:0] led_q;
  logic             fl_l;
  logic             fl;
  logic             tick;
  logic             busy;
  logic             at_kick;

  assign busy    = (state != IDLE);
  assign fl      = bus.flick | fl_l;
  assign at_kick = (cnt == K1) || (cnt == K2);

  assign bus.led   = led_q;
  assign bus.busy  = busy;
  assign bus.phase = state;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .tick(tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // count, bar image and pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      led_q <= '0;
      fl_l  <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      led_q <= N_LED'(therm(CNT_W_MAX'(cnt_n)));
      fl_l  <= tick ? 1'b0 : (fl_l | bus.flick);
    end
  end

  // phase walk: one count step or one transition per tick
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.flick) state_n = UP_A;
      end
      UP_A: begin
        if (tick) begin
          if (cnt == K1) state_n = DN_A;
          else           cnt_n = cnt + ONE;
        end
      end
      DN_A: begin
        if (tick) begin
          if (cnt == '0) state_n = UP_B;
          else           cnt_n = cnt - ONE;
        end
      end
      UP_B: begin
        if (tick) begin
          if (fl && at_kick) begin
            state_n = DN_A;
            cnt_n   = cnt - ONE;
          end else if (cnt == K2) begin
            state_n = DN_B;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      DN_B: begin
        if (tick) begin
          if (cnt == KB) state_n = UP_C;
          else           cnt_n = cnt - ONE;
        end
      end
      UP_C: begin
        if (tick) begin
          if (fl && at_kick) begin
            state_n = DN_B;
            cnt_n   = cnt - ONE;
          end else if (cnt == KN) begin
            state_n = DN_C;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      DN_C: begin
        if (tick) begin
          if (cnt == '0) begin
            state_n = (bus.loop_en || fl) ? UP_A : IDLE;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
